// File: rtl/multicycle_pkg.sv
// Shared opcodes, state encodings and datapath select codes for the multicycle CPU control.
package multicycle_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ST_W     = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP     = 6'b000000;
  localparam logic [OP_W-1:0] OP_J       = 6'b000001;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'b100000;
  localparam logic [OP_W-1:0] OP_BNE     = 6'b100001;
  localparam logic [OP_W-1:0] OP_BLT     = 6'b100010;
  localparam logic [OP_W-1:0] OP_BLE     = 6'b100011;
  localparam logic [OP_W-1:0] OP_R_FIRST = 6'b010000;
  localparam logic [OP_W-1:0] OP_R_LAST  = 6'b010111;
  localparam logic [OP_W-1:0] OP_I_FIRST = 6'b110000;
  localparam logic [OP_W-1:0] OP_I_LAST  = 6'b110111;
  localparam logic [OP_W-1:0] OP_LI      = 6'b111001;
  localparam logic [OP_W-1:0] OP_LUI     = 6'b111010;
  localparam logic [OP_W-1:0] OP_LWI     = 6'b111011;
  localparam logic [OP_W-1:0] OP_SWI     = 6'b111100;
  localparam logic [OP_W-1:0] OP_LW      = 6'b011100;
  localparam logic [OP_W-1:0] OP_SW      = 6'b011101;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_JUMP     = 4'd2,
    S_BRANCH   = 4'd3,
    S_EXEC_R   = 4'd4,
    S_EXEC_I   = 4'd5,
    S_EXEC_LI  = 4'd6,
    S_EXEC_LUI = 4'd7,
    S_ADDR     = 4'd8,
    S_MEMR     = 4'd9,
    S_MEMW     = 4'd10,
    S_WB_ALU   = 4'd11,
    S_WB_MEM   = 4'd12,
    S_WB_LI    = 4'd13,
    S_WB_LUI   = 4'd14
  } state_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_MOV    = 4'd0,
    ALU_NOT    = 4'd1,
    ALU_ADD    = 4'd2,
    ALU_SUB    = 4'd3,
    ALU_OR     = 4'd4,
    ALU_AND    = 4'd5,
    ALU_XOR    = 4'd6,
    ALU_SLT    = 4'd7,
    ALU_PASS_B = 4'd8
  } alu_op_e;

  typedef enum logic {
    PC_SRC_ALU = 1'b0,
    PC_SRC_TGT = 1'b1
  } pc_src_e;

  typedef enum logic [SEL_W-1:0] {
    SRC_A_PC   = 2'b00,
    SRC_A_REG  = 2'b01,
    SRC_A_ZERO = 2'b10
  } src_a_e;

  typedef enum logic [SEL_W-1:0] {
    SRC_B_REG = 2'b00,
    SRC_B_ONE = 2'b01,
    SRC_B_IMM = 2'b10
  } src_b_e;

  // Register read port mapping: names give the IR fields feeding A then B.
  typedef enum logic [SEL_W-1:0] {
    RF_A20_B15 = 2'b00,
    RF_A25_B20 = 2'b01,
    RF_A20_B25 = 2'b10
  } rf_sel_e;

  typedef enum logic [SEL_W-1:0] {
    WB_ALU_OUT   = 2'b00,
    WB_MDR       = 2'b01,
    WB_LI_MERGE  = 2'b10,
    WB_LUI_MERGE = 2'b11
  } wb_src_e;

  typedef enum logic [3:0] {
    CL_NOP    = 4'd0,
    CL_JUMP   = 4'd1,
    CL_BRANCH = 4'd2,
    CL_ALU_R  = 4'd3,
    CL_ALU_I  = 4'd4,
    CL_LI     = 4'd5,
    CL_LUI    = 4'd6,
    CL_LOAD   = 4'd7,
    CL_STORE  = 4'd8
  } iclass_e;

  typedef struct packed {
    iclass_e cls;
    logic    mem_abs;
    logic    illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_decode.sv
// Opcode classifier: maps IR[31:26] to an instruction class, absolute-address flag and illegal flag.
module multicycle_decode
  import multicycle_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  output dec_t            o_dec
);

  // Undefined opcodes fall back to the NOP class with the illegal flag raised.
  always_comb begin
    o_dec = '{cls: CL_NOP, mem_abs: 1'b0, illegal: 1'b0};
    case (i_opcode) inside
      OP_NOP:                         o_dec.cls = CL_NOP;
      OP_J:                           o_dec.cls = CL_JUMP;
      OP_BEQ, OP_BNE, OP_BLT, OP_BLE: o_dec.cls = CL_BRANCH;
      [OP_R_FIRST:OP_R_LAST]:         o_dec.cls = CL_ALU_R;
      [OP_I_FIRST:OP_I_LAST]:         o_dec.cls = CL_ALU_I;
      OP_LI:                          o_dec.cls = CL_LI;
      OP_LUI:                         o_dec.cls = CL_LUI;
      OP_LWI: begin
        o_dec.cls     = CL_LOAD;
        o_dec.mem_abs = 1'b1;
      end
      OP_LW:                          o_dec.cls = CL_LOAD;
      OP_SWI: begin
        o_dec.cls     = CL_STORE;
        o_dec.mem_abs = 1'b1;
      end
      OP_SW:                          o_dec.cls = CL_STORE;
      default:                        o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute/memory/writeback,
// drives every datapath enable and mux, and counts retired instructions.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter bit          MEM_WAIT_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 alu_zero,
  input  logic                 alu_neg,
  input  logic                 mem_ready,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 target_write,
  output logic [SEL_W-1:0]     alu_src_a,
  output logic [SEL_W-1:0]     alu_src_b,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic [SEL_W-1:0]     rf_sel,
  output logic                 reg_write,
  output logic [SEL_W-1:0]     wb_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ST_W-1:0]      state,
  output logic                 retire,
  output logic [CNT_W-1:0]     instr_count,
  output logic                 illegal_op
);

  state_e           r_state;
  state_e           w_next;
  dec_t             w_dec;
  logic             w_mem_done;
  logic             w_taken;
  logic [CNT_W-1:0] r_count;

  multicycle_decode u_decode (
    .i_opcode (opcode),
    .o_dec    (w_dec)
  );

  // Without wait support the memory is assumed to complete in one cycle.
  assign w_mem_done = !MEM_WAIT_EN || mem_ready;

  // Branch condition from the low opcode bits: BEQ, BNE, BLT, BLE.
  always_comb begin
    case (opcode[1:0])
      2'b00:   w_taken = alu_zero;
      2'b01:   w_taken = !alu_zero;
      2'b10:   w_taken = alu_neg;
      default: w_taken = alu_neg | alu_zero;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_count <= '0;
    else if (retire) r_count <= r_count + CNT_W'(1);
  end

  always_comb begin
    w_next       = r_state;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    target_write = 1'b0;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_REG;
    alu_op       = ALU_MOV;
    rf_sel       = RF_A20_B15;
    reg_write    = 1'b0;
    wb_src       = WB_ALU_OUT;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    retire       = 1'b0;
    illegal_op   = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_ALU;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_ONE;
        alu_op    = ALU_ADD;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // PC already points past this instruction, so targets are next-PC relative.
        target_write = 1'b1;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_IMM;
        alu_op       = ALU_ADD;
        case (w_dec.cls)
          CL_NOP: begin
            retire     = 1'b1;
            illegal_op = w_dec.illegal;
            w_next     = S_FETCH;
          end
          CL_JUMP:   w_next = S_JUMP;
          CL_BRANCH: w_next = S_BRANCH;
          CL_ALU_R:  w_next = S_EXEC_R;
          CL_ALU_I:  w_next = S_EXEC_I;
          CL_LI:     w_next = S_EXEC_LI;
          CL_LUI:    w_next = S_EXEC_LUI;
          default:   w_next = S_ADDR;
        endcase
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_TGT;
        retire   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        rf_sel    = RF_A25_B20;
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_SUB;
        pc_write  = w_taken;
        pc_src    = PC_SRC_TGT;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_EXEC_R: begin
        rf_sel    = RF_A20_B15;
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = {1'b0, opcode[2:0]};
        w_next    = S_WB_ALU;
      end
      S_EXEC_I: begin
        rf_sel    = RF_A20_B15;
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        alu_op    = {1'b0, opcode[2:0]};
        w_next    = S_WB_ALU;
      end
      S_EXEC_LI: begin
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_PASS_B;
        w_next    = S_WB_LI;
      end
      S_EXEC_LUI: begin
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_PASS_B;
        w_next    = S_WB_LUI;
      end
      S_ADDR: begin
        rf_sel    = RF_A20_B25;
        alu_src_a = w_dec.mem_abs ? SRC_A_ZERO : SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        w_next    = (w_dec.cls == CL_STORE) ? S_MEMW : S_MEMR;
      end
      S_MEMR: begin
        rf_sel   = RF_A20_B25;
        mem_read = 1'b1;
        if (w_mem_done) w_next = S_WB_MEM;
      end
      S_MEMW: begin
        // Retire only on the completing cycle so a waiting store counts once.
        rf_sel    = RF_A20_B25;
        mem_write = 1'b1;
        if (w_mem_done) begin
          retire = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        wb_src    = WB_ALU_OUT;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_src    = WB_MDR;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_WB_LI: begin
        reg_write = 1'b1;
        wb_src    = WB_LI_MERGE;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_WB_LUI: begin
        reg_write = 1'b1;
        wb_src    = WB_LUI_MERGE;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle expected control words for
// short programs, plus reset-abort, counter wrap and no-wait store sequences.
module tb_multicycle_control;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000001;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_BLE = 6'b100011;
  localparam logic [5:0] OP_ADD = 6'b010010;
  localparam logic [5:0] OP_LUI = 6'b111010;
  localparam logic [5:0] OP_LWI = 6'b111011;
  localparam logic [5:0] OP_SW  = 6'b011101;
  localparam logic [5:0] OP_BAD = 6'b101010;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_JUMP = 4'd2, S_BRANCH = 4'd3;
  localparam logic [3:0] S_EXEC_R = 4'd4, S_EXEC_LUI = 4'd7, S_ADDR = 4'd8, S_MEMR = 4'd9;
  localparam logic [3:0] S_MEMW = 4'd10, S_WB_ALU = 4'd11, S_WB_MEM = 4'd12, S_WB_LUI = 4'd14;

  // stb = {ir_write, pc_write, target_write, reg_write, mem_read, mem_write, retire, illegal_op}
  // msk selects which of {pc_src, alu_src_a, alu_src_b, alu_op, rf_sel, wb_src} are checked
  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       n;
    logic       rdy;
    logic [3:0] st;
    logic [7:0] stb;
    logic       pcs;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] aop;
    logic [1:0] rf;
    logic [1:0] wb;
    logic [5:0] msk;
    int         cnt;
  } vec_t;

  logic        clk, rst, zero, neg, rdy;
  logic [5:0]  op_a, op_b;

  logic        a_ir, a_pcw, a_pcs, a_tgt, a_rw, a_mr, a_mw, a_ret, a_ill;
  logic [1:0]  a_sa, a_sb, a_rf, a_wb;
  logic [3:0]  a_aop, a_state;
  logic [31:0] a_cnt;

  logic        b_ir, b_pcw, b_pcs, b_tgt, b_rw, b_mr, b_mw, b_ret, b_ill;
  logic [1:0]  b_sa, b_sb, b_rf, b_wb;
  logic [3:0]  b_aop, b_state;
  logic [3:0]  b_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  multicycle_control #(.CNT_W(32), .MEM_WAIT_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .opcode(op_a), .alu_zero(zero), .alu_neg(neg), .mem_ready(rdy),
    .ir_write(a_ir), .pc_write(a_pcw), .pc_src(a_pcs), .target_write(a_tgt),
    .alu_src_a(a_sa), .alu_src_b(a_sb), .alu_op(a_aop), .rf_sel(a_rf),
    .reg_write(a_rw), .wb_src(a_wb), .mem_read(a_mr), .mem_write(a_mw),
    .state(a_state), .retire(a_ret), .instr_count(a_cnt), .illegal_op(a_ill)
  );

  multicycle_control #(.CNT_W(4), .MEM_WAIT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .opcode(op_b), .alu_zero(zero), .alu_neg(neg), .mem_ready(rdy),
    .ir_write(b_ir), .pc_write(b_pcw), .pc_src(b_pcs), .target_write(b_tgt),
    .alu_src_a(b_sa), .alu_src_b(b_sb), .alu_op(b_aop), .rf_sel(b_rf),
    .reg_write(b_rw), .wb_src(b_wb), .mem_read(b_mr), .mem_write(b_mw),
    .state(b_state), .retire(b_ret), .instr_count(b_cnt), .illegal_op(b_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [5:0] op, input logic r, input logic [3:0] st,
                              input logic [7:0] stb, input logic pcs, input logic [1:0] a,
                              input logic [1:0] b, input logic [3:0] aop, input logic [1:0] rf,
                              input logic [1:0] wb, input logic [5:0] msk, input int cnt);
    vec_t v;
    v = '{op, 1'b0, 1'b1, r, st, stb, pcs, a, b, aop, rf, wb, msk, cnt};
    return v;
  endfunction

  function automatic vec_t fetch_v(input logic [5:0] op, input int cnt);
    return mk(op, 1'b0, S_FETCH, 8'b1100_0000, 1'b0, 2'd0, 2'd1, 4'd2, 2'd0, 2'd0, 6'b111100, cnt);
  endfunction

  function automatic vec_t decode_v(input logic [5:0] op, input logic [7:0] stb, input int cnt);
    return mk(op, 1'b0, S_DECODE, stb, 1'b0, 2'd0, 2'd2, 4'd2, 2'd0, 2'd0, 6'b011100, cnt);
  endfunction

  function automatic logic [12:0] expand(input logic [5:0] m);
    return {m[5], {2{m[4]}}, {2{m[3]}}, {4{m[2]}}, {2{m[1]}}, {2{m[0]}}};
  endfunction

  task automatic check_row(input string nm, input vec_t v, input logic [3:0] st,
                           input logic [7:0] stb, input logic [12:0] mux, input int cnt);
    logic [12:0] m;
    logic [12:0] em;
    m  = expand(v.msk);
    em = {v.pcs, v.a, v.b, v.aop, v.rf, v.wb};
    n_vec++;
    if (st !== v.st || stb !== v.stb || (mux & m) !== (em & m) || cnt != v.cnt) begin
      n_miss++;
      $display("FAIL %s: got st=%0d stb=%b mux=%h cnt=%0d, required st=%0d stb=%b mux=%h cnt=%0d",
               nm, st, stb, mux & m, cnt, v.st, v.stb, em & m, v.cnt);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  // Drive one row just after a falling edge, compare, then advance to the next falling edge.
  task automatic apply(input string nm, input vec_t v, input bit on_b);
    if (on_b) op_b = v.op;
    else      op_a = v.op;
    zero = v.z;
    neg  = v.n;
    rdy  = v.rdy;
    #1;
    if (on_b)
      check_row(nm, v, b_state, {b_ir, b_pcw, b_tgt, b_rw, b_mr, b_mw, b_ret, b_ill},
                {b_pcs, b_sa, b_sb, b_aop, b_rf, b_wb}, 32'(b_cnt));
    else
      check_row(nm, v, a_state, {a_ir, a_pcw, a_tgt, a_rw, a_mr, a_mw, a_ret, a_ill},
                {a_pcs, a_sa, a_sb, a_aop, a_rf, a_wb}, 32'(a_cnt));
    @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t tbl_b[$];

  initial begin
    // ADD: 4 cycles
    tbl.push_back(fetch_v(OP_ADD, 0));
    tbl.push_back(decode_v(OP_ADD, 8'b0010_0000, 0));
    tbl.push_back(mk(OP_ADD, 1'b0, S_EXEC_R, 8'b0, 1'b0, 2'd1, 2'd0, 4'd2, 2'd0, 2'd0, 6'b011110, 0));
    tbl.push_back(mk(OP_ADD, 1'b0, S_WB_ALU, 8'b0001_0010, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0, 6'b000001, 0));
    // BNE taken with zero=0
    tbl.push_back(fetch_v(OP_BNE, 1));
    tbl.push_back(decode_v(OP_BNE, 8'b0010_0000, 1));
    tbl.push_back(mk(OP_BNE, 1'b0, S_BRANCH, 8'b0100_0010, 1'b1, 2'd0, 2'd0, 4'd3, 2'd1, 2'd0, 6'b100110, 1));
    // BEQ not taken
    tbl.push_back(fetch_v(OP_BEQ, 2));
    tbl.push_back(decode_v(OP_BEQ, 8'b0010_0000, 2));
    tbl.push_back(mk(OP_BEQ, 1'b0, S_BRANCH, 8'b0000_0010, 1'b0, 2'd0, 2'd0, 4'd3, 2'd1, 2'd0, 6'b000110, 2));
    // BLE taken through neg
    tbl.push_back(fetch_v(OP_BLE, 3));
    tbl.push_back(decode_v(OP_BLE, 8'b0010_0000, 3));
    tbl.push_back(mk(OP_BLE, 1'b0, S_BRANCH, 8'b0100_0010, 1'b1, 2'd0, 2'd0, 4'd3, 2'd1, 2'd0, 6'b100110, 3));
    // illegal opcode: 2 cycles
    tbl.push_back(fetch_v(OP_BAD, 4));
    tbl.push_back(decode_v(OP_BAD, 8'b0010_0011, 4));
    // J
    tbl.push_back(fetch_v(OP_J, 5));
    tbl.push_back(decode_v(OP_J, 8'b0010_0000, 5));
    tbl.push_back(mk(OP_J, 1'b0, S_JUMP, 8'b0100_0010, 1'b1, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0, 6'b100000, 5));
    // LWI with three wait cycles: 8 cycles
    tbl.push_back(fetch_v(OP_LWI, 6));
    tbl.push_back(decode_v(OP_LWI, 8'b0010_0000, 6));
    tbl.push_back(mk(OP_LWI, 1'b0, S_ADDR, 8'b0, 1'b0, 2'd2, 2'd2, 4'd2, 2'd2, 2'd0, 6'b011110, 6));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(OP_LWI, (i == 3), S_MEMR, 8'b0000_1000, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0, 6'b000000, 6));
    tbl.push_back(mk(OP_LWI, 1'b0, S_WB_MEM, 8'b0001_0010, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd1, 6'b000001, 6));
    // LUI
    tbl.push_back(fetch_v(OP_LUI, 7));
    tbl.push_back(decode_v(OP_LUI, 8'b0010_0000, 7));
    tbl.push_back(mk(OP_LUI, 1'b0, S_EXEC_LUI, 8'b0, 1'b0, 2'd0, 2'd2, 4'd8, 2'd0, 2'd0, 6'b001100, 7));
    tbl.push_back(mk(OP_LUI, 1'b0, S_WB_LUI, 8'b0001_0010, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd3, 6'b000001, 7));
    // LWI left stalled in MEMR for the reset-abort sequence
    tbl.push_back(fetch_v(OP_LWI, 8));
    tbl.push_back(decode_v(OP_LWI, 8'b0010_0000, 8));
    tbl.push_back(mk(OP_LWI, 1'b0, S_ADDR, 8'b0, 1'b0, 2'd2, 2'd2, 4'd2, 2'd2, 2'd0, 6'b011110, 8));
    tbl.push_back(mk(OP_LWI, 1'b0, S_MEMR, 8'b0000_1000, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0, 6'b000000, 8));

    // SW on the no-wait instance: completes despite mem_ready low
    tbl_b.push_back(fetch_v(OP_SW, 1));
    tbl_b.push_back(decode_v(OP_SW, 8'b0010_0000, 1));
    tbl_b.push_back(mk(OP_SW, 1'b0, S_ADDR, 8'b0, 1'b0, 2'd1, 2'd2, 4'd2, 2'd2, 2'd0, 6'b011110, 1));
    tbl_b.push_back(mk(OP_SW, 1'b0, S_MEMW, 8'b0000_0110, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0, 6'b000000, 1));
    tbl_b.push_back(fetch_v(OP_SW, 2));

    rst  = 1'b1;
    op_a = OP_NOP;
    op_b = OP_NOP;
    zero = 1'b0;
    neg  = 1'b1;
    rdy  = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_state", 32'(a_state), 32'(S_FETCH));
    chk("reset_count", a_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i], 1'b0);

    // Two-cycle reset while the load waits in MEMR
    rst = 1'b1;
    #1;
    chk("memr_before_reset", 32'(a_state), 32'(S_MEMR));
    @(negedge clk);
    #1;
    chk("memr_reset_state", 32'(a_state), 32'(S_FETCH));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_state", 32'(a_state), 32'(S_FETCH));
    chk("post_reset_count", a_cnt, 0);
    chk("post_reset_strobes", 32'({a_rw, a_mr, a_mw, a_ret, a_ill}), 0);

    // 17 NOPs on both instances; the 4-bit counter wraps to 1
    op_a = OP_NOP;
    op_b = OP_NOP;
    repeat (34) @(negedge clk);
    #1;
    chk("nop17_count_32b", a_cnt, 17);
    chk("nop17_count_wrap", 32'(b_cnt), 1);
    chk("nop17_state", 32'(b_state), 32'(S_FETCH));

    foreach (tbl_b[i]) apply($sformatf("nowait_row%0d", i), tbl_b[i], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
